// File: rtl/spi_master_multi.sv
// spi_master_multi: single-clock SPI master (CPHA=0, selectable CPOL), NUM_CS selects, programmable
// SCK divider and held chip select. Define SPI_MASTER_TIMEOUT_EN to bound the WaitAndRead filler wait.
module spi_master_multi #(
    parameter int NUM_CS    = 4,
    parameter int LEN_W     = 10,
    parameter int DIV_W     = 8,
    parameter int TIMEOUT_W = 12,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              TransferClk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DIV_W-1:0]  ClkDiv,
    input  logic              Cpol,
    input  logic [CS_W-1:0]   CsSel,
    input  logic              CsHold,
    input  logic              Abort,
    output logic              Sck,
    output logic              Mosi,
    input  logic              Miso,
    output logic [NUM_CS-1:0] nCs,
    output logic [LEN_W-1:0]  TxRdAddr,
    input  logic [7:0]        TxRdData,
    output logic              RxWrEn,
    output logic [LEN_W-1:0]  RxWrAddr,
    output logic [7:0]        RxWrData,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted
);

    localparam logic [1:0] MODE_WRITE = 2'd0;
    localparam logic [1:0] MODE_READ  = 2'd1;
    localparam logic [1:0] MODE_WAIT  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_CS_GAP, ST_LOAD, ST_SHIFT} state_t;

    state_t r_state, w_state_next;

    logic [1:0]        r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol;
    logic [CS_W-1:0]   r_cs_sel;
    logic              r_cs_hold;
    logic [7:0]        r_shreg;
    logic [7:0]        r_rx;
    logic [2:0]        r_bit;
    logic              r_phase;
    logic [DIV_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_idx;
    logic              r_found;
    logic [LEN_W-1:0]  r_tx_addr;
    logic [NUM_CS-1:0] r_ncs;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              r_rx_en;
    logic [LEN_W-1:0]  r_rx_addr;
    logic [7:0]        r_rx_data;

    logic              w_start;
    logic              w_cs_switch;
    logic              w_half_end;
    logic              w_sample;
    logic              w_bit_end;
    logic              w_byte_end;
    logic              w_filler;
    logic              w_store;
    logic              w_timeout;
    logic              w_finish;
    logic              w_mosi_en;
    logic [NUM_CS-1:0] w_sel_in_n;
    logic [NUM_CS-1:0] w_sel_held_n;

    // Active-low one-hot decode of the requested and the latched select
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
        assign w_sel_in_n[gi]   = (CsSel != CS_W'(gi));
        assign w_sel_held_n[gi] = (r_cs_sel != CS_W'(gi));
    end

    assign w_start     = (r_state == ST_IDLE) && Start;
    assign w_cs_switch = w_start && (r_ncs != '1) && (CsSel != r_cs_sel);
    assign w_half_end  = (r_state == ST_SHIFT) && (r_cnt == r_div);
    assign w_sample    = w_half_end && !r_phase;
    assign w_bit_end   = w_half_end && r_phase;
    assign w_byte_end  = w_bit_end && (r_bit == 3'd7);
    assign w_filler    = (r_mode == MODE_WAIT) && !r_found && (r_rx == 8'hFF);
    assign w_store     = w_byte_end && !w_filler && (r_mode != MODE_WRITE);
    assign w_finish    = w_byte_end && ((!w_filler && (r_idx == r_len)) || Abort || w_timeout);
    assign w_mosi_en   = (r_mode != MODE_READ) && (r_mode != MODE_WAIT);

`ifdef SPI_MASTER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_fill_cnt;
    logic [TIMEOUT_W-1:0] w_fill_inc;

    assign w_fill_inc = r_fill_cnt + 1'b1;
    assign w_timeout  = w_byte_end && w_filler && (w_fill_inc == '1);

    always_ff @(posedge TransferClk) begin
        if (Reset || w_start) begin
            r_fill_cnt <= '0;
        end else if (w_byte_end && w_filler) begin
            r_fill_cnt <= w_fill_inc;
        end
    end
`else
    // No filler counter: the wait is broken only by Abort or Reset.
    assign w_timeout = (TIMEOUT_W < 0);
`endif

    always_ff @(posedge TransferClk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (Start) w_state_next = w_cs_switch ? ST_CS_GAP : ST_LOAD;
            ST_CS_GAP: w_state_next = ST_LOAD;
            ST_LOAD:   w_state_next = ST_SHIFT;
            ST_SHIFT:  if (w_finish) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge TransferClk) begin
        if (Reset) begin
            r_mode    <= MODE_WRITE;
            r_len     <= '0;
            r_div     <= '0;
            r_cpol    <= 1'b0;
            r_cs_sel  <= '0;
            r_cs_hold <= 1'b0;
            r_shreg   <= '0;
            r_rx      <= '0;
            r_bit     <= '0;
            r_phase   <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_found   <= 1'b0;
            r_tx_addr <= '0;
            r_ncs     <= '1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_rx_en   <= 1'b0;
            r_rx_addr <= '0;
            r_rx_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_rx_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_mode    <= Mode;
                        r_len     <= Len;
                        r_div     <= ClkDiv;
                        r_cpol    <= Cpol;
                        r_cs_sel  <= CsSel;
                        r_cs_hold <= CsHold;
                        r_idx     <= '0;
                        r_found   <= 1'b0;
                        r_tx_addr <= '0;
                        r_busy    <= 1'b1;
                        r_aborted <= 1'b0;
                        // A held select on another device is dropped for one cycle first
                        r_ncs     <= w_cs_switch ? '1 : w_sel_in_n;
                    end
                end
                ST_CS_GAP: begin
                    r_ncs <= w_sel_held_n;
                end
                ST_LOAD: begin
                    r_shreg <= TxRdData;
                    r_bit   <= '0;
                    r_phase <= 1'b0;
                    r_cnt   <= '0;
                end
                ST_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_sample) begin
                        r_rx <= {r_rx[6:0], Miso};
                    end
                    if (w_bit_end && !w_byte_end) begin
                        r_bit   <= r_bit + 1'b1;
                        r_shreg <= {r_shreg[6:0], 1'b0};
                        // Prefetch the next TX byte so it is ready at the byte boundary
                        if (r_bit == 3'd5) begin
                            r_tx_addr <= r_idx + 1'b1;
                        end
                    end
                    if (w_finish) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= Abort || w_timeout;
                        r_tx_addr <= '0;
                        if (!r_cs_hold) begin
                            r_ncs <= '1;
                        end
                    end else if (w_byte_end) begin
                        r_shreg <= TxRdData;
                        r_bit   <= '0;
                        if (!w_filler) begin
                            r_idx   <= r_idx + 1'b1;
                            r_found <= 1'b1;
                        end
                    end
                    if (w_store) begin
                        r_rx_en   <= 1'b1;
                        r_rx_addr <= r_idx;
                        r_rx_data <= r_rx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sck      = ((r_state == ST_SHIFT) && r_phase) ? ~r_cpol : r_cpol;
    assign Mosi     = ((r_state == ST_SHIFT) && w_mosi_en) ? r_shreg[7] : 1'b1;
    assign nCs      = r_ncs;
    assign TxRdAddr = r_tx_addr;
    assign RxWrEn   = r_rx_en;
    assign RxWrAddr = r_rx_addr;
    assign RxWrData = r_rx_data;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Aborted  = r_aborted;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed checks of spi_master_multi with a registered-read TX buffer model
// and a CPHA=0 SPI slave that shifts out a preset MISO word.
module tb_spi_master_multi;

    localparam int NUM_CS = 4;
    localparam int LEN_W  = 10;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              reset, start, cpol, cs_hold, abort;
    logic [1:0]        mode;
    logic [LEN_W-1:0]  len;
    logic [DIV_W-1:0]  clk_div;
    logic [1:0]        cs_sel;
    logic              sck, mosi, miso;
    logic [NUM_CS-1:0] n_cs;
    logic [LEN_W-1:0]  tx_rd_addr, rx_wr_addr;
    logic [7:0]        tx_rd_data, rx_wr_data;
    logic              rx_wr_en, busy, done, aborted;

    always #5 clk = ~clk;

    spi_master_multi #(.NUM_CS(NUM_CS), .LEN_W(LEN_W), .DIV_W(DIV_W), .TIMEOUT_W(12)) dut (
        .TransferClk(clk), .Reset(reset), .Start(start), .Mode(mode), .Len(len),
        .ClkDiv(clk_div), .Cpol(cpol), .CsSel(cs_sel), .CsHold(cs_hold), .Abort(abort),
        .Sck(sck), .Mosi(mosi), .Miso(miso), .nCs(n_cs), .TxRdAddr(tx_rd_addr),
        .TxRdData(tx_rd_data), .RxWrEn(rx_wr_en), .RxWrAddr(rx_wr_addr), .RxWrData(rx_wr_data),
        .Busy(busy), .Done(done), .Aborted(aborted)
    );

    logic [7:0] tx_mem [0:1023];
    always @(posedge clk) tx_rd_data <= tx_mem[tx_rd_addr];

    int checks = 0;
    int failures = 0;
    int cyc = 0, last_edge = 0, half_len = 0;
    int sck_pulses = 0, done_cnt = 0, busy_cyc = 0, rx_cnt = 0, ncs_bad = 0;
    int miso_base = 0;
    logic [31:0] miso_word = '1;
    logic [31:0] mosi_word = '0;
    logic        prev_sck = 1'b0;
    logic        cpol_tb = 1'b0;
    logic [1:0]  cs_tb = 2'd0;
    logic [LEN_W-1:0] rx_addr_log [0:31];
    logic [7:0]       rx_data_log [0:31];

    // Slave presents MISO bit k after k completed leading edges (CPHA=0)
    always_comb begin
        int k;
        k = sck_pulses - miso_base;
        miso = 1'b1;
        if (k >= 0 && k < 32) miso = miso_word[5'(31 - k)];
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_wr_en) begin
            if (rx_cnt < 32) begin
                rx_addr_log[5'(rx_cnt)] = rx_wr_addr;
                rx_data_log[5'(rx_cnt)] = rx_wr_data;
            end
            rx_cnt++;
        end
        if (done) done_cnt++;
        if (busy) begin
            busy_cyc++;
            if (n_cs[cs_tb] !== 1'b0) ncs_bad++;
        end
        if (sck !== prev_sck) begin
            half_len  = cyc - last_edge;
            last_edge = cyc;
            if (sck === ~cpol_tb) begin
                sck_pulses++;
                mosi_word = {mosi_word[30:0], mosi};
            end
        end
        prev_sck = sck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int l, input int d, input logic cp,
                            input logic [1:0] sel, input logic hold);
        @(negedge clk);
        mode = m; len = LEN_W'(l); clk_div = DIV_W'(d); cpol = cp; cs_sel = sel; cs_hold = hold;
        cpol_tb = cp; cs_tb = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        bit got;
        n = 0; got = 1'b0;
        while (!got && n < max_cyc) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
            n++;
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL %s_done_wait observed=0 expected=1", tag);
        end
        @(negedge clk);
    endtask

    int b_sck, b_done, b_busy, b_rx, b_ncs;

    task automatic snap();
        b_sck = sck_pulses; b_done = done_cnt; b_busy = busy_cyc; b_rx = rx_cnt; b_ncs = ncs_bad;
        miso_base = sck_pulses;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'd0; len = '0; clk_div = '0; cpol = 1'b0;
        cs_sel = 2'd0; cs_hold = 1'b0; abort = 1'b0;
        for (int i = 0; i < 1024; i++) tx_mem[10'(i)] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rxwren", 32'(rx_wr_en), 32'h0);
        check("rst_aborted", 32'(aborted), 32'h0);
        check("rst_sck", 32'(sck), 32'h0);
        check("rst_mosi", 32'(mosi), 32'h1);
        check("rst_ncs", 32'(n_cs), 32'hF);
        check("rst_txaddr", 32'(tx_rd_addr), 32'h0);

        // Write, Len=2, full rate
        tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'hFF; miso_word = '1;
        snap();
        do_start(2'd0, 2, 0, 1'b0, 2'd1, 1'b0);
        check("wr_ncs_sel", 32'(n_cs), 32'hD);
        wait_done(200, "wr");
        check("wr_pulses", sck_pulses - b_sck, 32'd24);
        check("wr_mosi", {8'h0, mosi_word[23:0]}, 32'hA53CFF);
        check("wr_busy_cycles", busy_cyc - b_busy, 32'd49);
        check("wr_strobes", rx_cnt - b_rx, 32'd0);
        check("wr_done_pulses", done_cnt - b_done, 32'd1);
        check("wr_ncs_low", ncs_bad - b_ncs, 32'd0);
        check("wr_ncs_release", 32'(n_cs), 32'hF);
        check("wr_busy_end", 32'(busy), 32'h0);
        check("wr_sck_idle", 32'(sck), 32'h0);

        // Exchange, Len=0, ClkDiv=3
        tx_mem[0] = 8'h81; miso_word = 32'h5AFF_FFFF;
        snap();
        do_start(2'd2, 0, 3, 1'b0, 2'd2, 1'b0);
        wait_done(200, "xchg");
        check("xchg_strobes", rx_cnt - b_rx, 32'd1);
        check("xchg_data", 32'(rx_data_log[5'(b_rx)]), 32'h5A);
        check("xchg_addr", 32'(rx_addr_log[5'(b_rx)]), 32'h0);
        check("xchg_half_period", half_len, 32'd4);
        check("xchg_busy_cycles", busy_cyc - b_busy, 32'd65);
        check("xchg_mosi", {24'h0, mosi_word[7:0]}, 32'h81);
        check("xchg_pulses", sck_pulses - b_sck, 32'd8);

        // WaitAndRead, Len=1, two fillers; a Start while busy must be ignored
        miso_word = 32'hFFFF_1234;
        snap();
        do_start(2'd3, 1, 0, 1'b0, 2'd0, 1'b0);
        repeat (10) @(negedge clk);
        mode = 2'd0; cs_sel = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "wrd");
        check("wrd_strobes", rx_cnt - b_rx, 32'd2);
        check("wrd_addr0", 32'(rx_addr_log[5'(b_rx)]), 32'h0);
        check("wrd_data0", 32'(rx_data_log[5'(b_rx)]), 32'h12);
        check("wrd_addr1", 32'(rx_addr_log[5'(b_rx + 1)]), 32'h1);
        check("wrd_data1", 32'(rx_data_log[5'(b_rx + 1)]), 32'h34);
        check("wrd_pulses", sck_pulses - b_sck, 32'd32);
        check("wrd_mosi_ones", mosi_word, 32'hFFFF_FFFF);
        check("wrd_busy_cycles", busy_cyc - b_busy, 32'd65);
        check("wrd_ncs_low", ncs_bad - b_ncs, 32'd0);

        // Cpol=1 with held select, then a release transfer on the same select
        tx_mem[0] = 8'h0F;
        snap();
        do_start(2'd0, 0, 1, 1'b1, 2'd3, 1'b1);
        check("cpol_sck_load", 32'(sck), 32'h1);
        wait_done(200, "hold1");
        check("hold1_ncs", 32'(n_cs), 32'h7);
        check("hold1_sck_idle", 32'(sck), 32'h1);
        repeat (5) @(negedge clk);
        check("hold1_ncs_idle", 32'(n_cs), 32'h7);
        do_start(2'd0, 0, 1, 1'b1, 2'd3, 1'b0);
        check("hold2_ncs_start", 32'(n_cs), 32'h7);
        wait_done(200, "hold2");
        check("hold2_ncs_release", 32'(n_cs), 32'hF);
        check("hold2_sck_idle", 32'(sck), 32'h1);
        check("hold_done_pulses", done_cnt - b_done, 32'd2);
        check("hold_ncs_low", ncs_bad - b_ncs, 32'd0);
        check("hold2_mosi", {24'h0, mosi_word[7:0]}, 32'h0F);

        // Held select followed by a Start on a different select
        do_start(2'd0, 0, 0, 1'b0, 2'd0, 1'b1);
        wait_done(200, "sw1");
        check("sw1_ncs_held", 32'(n_cs), 32'hE);
        do_start(2'd0, 0, 0, 1'b0, 2'd1, 1'b0);
        check("sw_ncs_gap", 32'(n_cs), 32'hF);
        check("sw_busy_gap", 32'(busy), 32'h1);
        @(negedge clk);
        check("sw_ncs_new", 32'(n_cs), 32'hD);
        wait_done(200, "sw2");
        check("sw2_ncs_release", 32'(n_cs), 32'hF);

        // Abort raised mid byte 1 of an 8-byte exchange
        miso_word = 32'hC35A_0000;
        snap();
        do_start(2'd2, 7, 0, 1'b0, 2'd2, 1'b0);
        for (int n = 0; n < 200 && (sck_pulses - b_sck) < 12; n++) @(negedge clk);
        abort = 1'b1;
        wait_done(400, "abort");
        abort = 1'b0;
        check("abort_strobes", rx_cnt - b_rx, 32'd2);
        check("abort_data0", 32'(rx_data_log[5'(b_rx)]), 32'hC3);
        check("abort_addr1", 32'(rx_addr_log[5'(b_rx + 1)]), 32'h1);
        check("abort_data1", 32'(rx_data_log[5'(b_rx + 1)]), 32'h5A);
        check("abort_flag", 32'(aborted), 32'h1);
        check("abort_pulses", sck_pulses - b_sck, 32'd16);
        check("abort_done_pulses", done_cnt - b_done, 32'd1);

        // Reset in the middle of a bit, then a normal transfer
        snap();
        do_start(2'd0, 3, 2, 1'b0, 2'd1, 1'b0);
        check("rstmid_aborted_cleared", 32'(aborted), 32'h0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_ncs", 32'(n_cs), 32'hF);
        check("rstmid_sck", 32'(sck), 32'h0);
        repeat (100) @(negedge clk);
        check("rstmid_no_done", done_cnt - b_done, 32'd0);
        tx_mem[0] = 8'h69;
        snap();
        do_start(2'd0, 0, 0, 1'b0, 2'd1, 1'b0);
        wait_done(200, "post_rst");
        check("post_rst_mosi", {24'h0, mosi_word[7:0]}, 32'h69);
        check("post_rst_done", done_cnt - b_done, 32'd1);
        check("post_rst_aborted", 32'(aborted), 32'h0);

        // Maximum length: 1024 bytes, index wraps only after the last byte
        tx_mem[0] = 8'h5A;
        snap();
        do_start(2'd0, 1023, 0, 1'b0, 2'd0, 1'b0);
        wait_done(20000, "maxlen");
        check("maxlen_pulses", sck_pulses - b_sck, 32'd8192);
        check("maxlen_busy_cycles", busy_cyc - b_busy, 32'd16385);
        check("maxlen_done_pulses", done_cnt - b_done, 32'd1);
        check("maxlen_last_byte", {24'h0, mosi_word[7:0]}, 32'hA5);
        check("maxlen_txaddr_idle", 32'(tx_rd_addr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
